d_latch_strobe_driver: RTL

// - Write-side driver for a bank of level-sensitive D latches: drives the latch data (D) and enable (C).
// - Takes one word per valid/ready handshake. Runs a timed setup -> enable pulse -> hold sequence.
// - Reads back Q/Qn after the sequence and reports done and error.
// - Sits between a clocked producer and a latch bank, so latch timing is generated on the clock.

---
 rtl/d_latch_strobe_driver.sv | 115 +++++++++++
 1 files changed

// File: rtl/d_latch_strobe_driver.sv
// Clocked write driver for a level-sensitive D latch bank: setup -> enable pulse -> hold,
// then Q/Qn readback with done/err reporting.
module d_latch_strobe_driver #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] latch_d,
  output logic             latch_c,
  input  logic [WIDTH-1:0] latch_q,
  input  logic [WIDTH-1:0] latch_qn,
  input  logic             clr_err,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             err_sticky
);

  localparam int MAXSP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAXC  = (MAXSP > HOLD_CYC) ? MAXSP : HOLD_CYC;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] exp_word, exp_nxt, latch_d_nxt;
  logic             latch_c_nxt, done_nxt, err_nxt, mismatch;

  assign in_ready = (state == IDLE) && rst_n;
  assign busy     = (state != IDLE);
  assign mismatch = (latch_q != exp_word) || (latch_qn != ~exp_word);

  // Each timed phase loads cnt with its length minus one and leaves when it reaches zero.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    latch_d_nxt = latch_d;
    latch_c_nxt = latch_c;
    exp_nxt     = exp_word;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          latch_d_nxt = in_data;
          exp_nxt     = in_data;
          cnt_nxt     = CW'(SETUP_CYC - 1);
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          latch_c_nxt = 1'b1;
          cnt_nxt     = CW'(PULSE_CYC - 1);
          state_nxt   = PULSE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          latch_c_nxt = 1'b0;
          cnt_nxt     = CW'(HOLD_CYC - 1);
          state_nxt   = HOLD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) state_nxt = CHECK;
        else           cnt_nxt   = cnt - CW'(1);
      end
      CHECK: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        err_nxt   = mismatch;
      end
      default: begin
        state_nxt   = IDLE;
        latch_c_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      latch_d    <= '0;
      latch_c    <= 1'b0;
      exp_word   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      latch_d    <= latch_d_nxt;
      latch_c    <= latch_c_nxt;
      exp_word   <= exp_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      // A new error wins over a simultaneous clear.
      err_sticky <= err_nxt | (err_sticky & ~clr_err);
    end
  end

endmodule
